// File: rtl/hdmi_pix_packer_if.sv
// Write-side handshake between the pixel packer FIFO and the frame-buffer write arbiter.
// The master drives the FIFO head; the slave answers with wr_ready.
interface hdmi_pix_packer_if #(
  parameter int PACK_W = 128
);
  logic [PACK_W-1:0] wr_data;
  logic              wr_sof;
  logic              wr_eol;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output wr_data, wr_sof, wr_eol, wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data, wr_sof, wr_eol, wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/hdmi_pix_packer.sv
// Packs the decimated RGB565 stream into PACK_W-bit words with SOF/EOL markers behind a FWFT FIFO.
// Optional status counters (frame_lines, line_pixels) are built only with HDMI_PACK_STATUS_EN.
module hdmi_pix_packer #(
  parameter int PACK_W     = 128,
  parameter int FIFO_DEPTH = 64,
  parameter int LINE_W     = 1280
) (
  input  logic                        hdmi_pix_clk_in,
  input  logic                        rst,
  input  logic                        vs_in,
  input  logic                        de_in,
  input  logic [15:0]                 rgb565_in,
  input  logic                        clear_err,
  hdmi_pix_packer_if.master           wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        line_err,
  output logic [11:0]                 frame_lines,
  output logic [11:0]                 line_pixels
);

  localparam int PPW = PACK_W / 16;
  localparam int CW  = $clog2(PPW + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = PACK_W + 2;

  localparam logic [CW-1:0] PPW_C    = CW'(PPW);
  localparam logic [11:0]   LINE_W_C = 12'(LINE_W);
  localparam logic [LW-1:0] DEPTH_C  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    ACTIVE,
    DROP
  } state_t;

  state_t            state_q;
  logic              vs_d_q;
  logic              sof_pend_q;
  logic [PACK_W-1:0] word_q;
  logic [CW-1:0]     cnt_q;
  logic [11:0]       pix_cnt_q;

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     head;

  logic overflow_q;
  logic line_err_q;

  logic vs_rise;
  logic push;
  logic push_eol;
  logic pop;
  logic full;
  logic push_acc;
  logic lost;
  logic line_end;
  logic line_bad;
  logic line_abort;

  assign vs_rise = vs_in & ~vs_d_q;
  assign full    = (level_q == DEPTH_C);
  assign pop     = wr.wr_valid & wr.wr_ready;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    push       = 1'b0;
    push_eol   = 1'b0;
    line_end   = 1'b0;
    line_abort = 1'b0;
    if (state_q == ACTIVE) begin
      if (vs_rise) begin
        line_abort = 1'b1;
      end else begin
        // A full word goes out on the following edge; a falling de_in flushes whatever is held.
        push     = (cnt_q == PPW_C) | ~de_in;
        push_eol = ~de_in;
        line_end = ~de_in;
      end
    end
  end

  assign push_acc = push & (~full | pop);
  assign lost     = push & full & ~pop;
  assign line_bad = line_end & (pix_cnt_q != LINE_W_C);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge hdmi_pix_clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      vs_d_q     <= 1'b0;
      sof_pend_q <= 1'b0;
      word_q     <= '0;
      cnt_q      <= '0;
      pix_cnt_q  <= '0;
    end else begin
      vs_d_q <= vs_in;
      if (push_acc) begin
        sof_pend_q <= 1'b0;
      end
      if (vs_rise) begin
        state_q    <= WAIT_LINE;
        sof_pend_q <= 1'b1;
        cnt_q      <= '0;
        pix_cnt_q  <= '0;
      end else begin
        case (state_q)
          WAIT_LINE: begin
            if (de_in) begin
              word_q    <= PACK_W'(rgb565_in);
              cnt_q     <= CW'(1);
              pix_cnt_q <= 12'd1;
              state_q   <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (lost) begin
              cnt_q   <= '0;
              state_q <= DROP;
            end else if (de_in) begin
              if (cnt_q == PPW_C) begin
                word_q <= PACK_W'(rgb565_in);
                cnt_q  <= CW'(1);
              end else begin
                word_q[16*cnt_q +: 16] <= rgb565_in;
                cnt_q                  <= cnt_q + CW'(1);
              end
              if (pix_cnt_q != 12'hFFF) begin
                pix_cnt_q <= pix_cnt_q + 12'd1;
              end
            end else begin
              cnt_q     <= '0;
              pix_cnt_q <= '0;
              state_q   <= WAIT_LINE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and level alone define which entries are live.
  always_ff @(posedge hdmi_pix_clk_in) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= {sof_pend_q, push_eol, word_q};
    end
  end

  always_ff @(posedge hdmi_pix_clk_in) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge hdmi_pix_clk_in) begin
    if (rst) begin
      overflow_q <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      overflow_q <= (overflow_q & ~clear_err) | lost;
      line_err_q <= (line_err_q & ~clear_err) | line_bad | line_abort;
    end
  end

  assign head        = mem[rd_ptr_q];
  assign wr.wr_valid = (level_q != '0);
  // Head is masked while empty so the outputs read zero after reset.
  assign wr.wr_data  = wr.wr_valid ? head[PACK_W-1:0] : '0;
  assign wr.wr_eol   = wr.wr_valid & head[PACK_W];
  assign wr.wr_sof   = wr.wr_valid & head[PACK_W+1];
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign line_err    = line_err_q;

`ifdef HDMI_PACK_STATUS_EN
  logic [11:0] lines_cnt_q;
  logic [11:0] frame_lines_q;
  logic [11:0] line_pixels_q;

  always_ff @(posedge hdmi_pix_clk_in) begin
    if (rst) begin
      lines_cnt_q   <= '0;
      frame_lines_q <= '0;
      line_pixels_q <= '0;
    end else begin
      if (vs_rise) begin
        frame_lines_q <= lines_cnt_q;
        lines_cnt_q   <= '0;
      end else if (line_end && (lines_cnt_q != 12'hFFF)) begin
        lines_cnt_q <= lines_cnt_q + 12'd1;
      end
      if (line_end) begin
        line_pixels_q <= pix_cnt_q;
      end
    end
  end

  assign frame_lines = frame_lines_q;
  assign line_pixels = line_pixels_q;
`else
  assign frame_lines = '0;
  assign line_pixels = '0;
`endif

endmodule
